// File: rtl/johnson_decoder.sv
// johnson_decoder
//   Samples a WIDTH-bit Johnson code on each strobe, decodes it to a binary
//   phase index, checks legality and single-step advance, and tracks lock.
//
// Parameters
//   WIDTH     Johnson code width (sequence length N = 2*WIDTH, WIDTH >= 2)
//   LOCK_CNT  consecutive correct successor steps needed to lock (1..15)
//   IW        index width, $clog2(2*WIDTH)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   en           sample strobe
//   code         Johnson code under test
//   index        phase of the last legal sample
//   valid        pulse: legal code decoded on the previous sampling edge
//   locked       sequence lock status
//   err_illegal  pulse: sampled code is not a Johnson state
//   err_seq      pulse: legal but wrong successor while locked
//   err_count    saturating count of error pulses
//
// Build option
//   JOHNSON_DEC_STALL_EN  when defined, a repeated index is accepted silently
//                         (tolerates a pausing source counter); otherwise it
//                         is treated as a wrong successor.

module johnson_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  localparam int N       = 2 * WIDTH,
  localparam int IW      = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] code,
  output logic [IW-1:0]    index,
  output logic             valid,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [7:0]       err_count
);

  localparam int RW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] prev_idx;
  logic [RW-1:0] run;
  logic          first;

  logic          legal;
  logic [IW-1:0] idx;
  logic [IW-1:0] nxt_idx;
  logic          is_succ;
  int            nbound;
  int            pop;

  // A Johnson state has at most one 0/1 boundary between adjacent bits;
  // that gives exactly 2*WIDTH legal codes.
  always_comb begin
    nbound = 0;
    pop    = 0;
    for (int i = 0; i < WIDTH - 1; i++)
      if (code[i] != code[i+1]) nbound = nbound + 1;
    for (int i = 0; i < WIDTH; i++)
      if (code[i]) pop = pop + 1;
    legal = (nbound <= 1);
    // Filling phase (msb=0) counts ones; draining phase counts down from N.
    idx   = code[WIDTH-1] ? IW'(N - pop) : IW'(pop);
  end

  assign nxt_idx = (prev_idx == IW'(N - 1)) ? '0 : prev_idx + 1'b1;
  assign is_succ = (idx == nxt_idx);
  assign locked  = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HUNT;
      prev_idx    <= '0;
      run         <= '0;
      first       <= 1'b1;
      index       <= '0;
      valid       <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_count   <= '0;
    end else begin
      valid       <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      if (en) begin
        if (!legal) begin
          // index/prev_idx hold so recovery is judged against the last good phase
          err_illegal <= 1'b1;
          run         <= '0;
          state       <= HUNT;
          if (err_count != 8'hff) err_count <= err_count + 8'd1;
        end else begin
          valid    <= 1'b1;
          index    <= idx;
          prev_idx <= idx;
          first    <= 1'b0;
          if (first) begin
            // reference point only: no step is judged
          end else if (is_succ) begin
            if (state == HUNT) begin
              run <= run + 1'b1;
              if (run == RW'(LOCK_CNT - 1)) state <= LOCKED;
            end
          end
`ifdef JOHNSON_DEC_STALL_EN
          else if (idx == prev_idx) begin
            // paused source: keep state and run as they are
          end
`endif
          else begin
            if (state == LOCKED) begin
              err_seq <= 1'b1;
              if (err_count != 8'hff) err_count <= err_count + 8'd1;
            end
            state <= HUNT;
            run   <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (WIDTH=4, LOCK_CNT=3).
// The driver pushes the reference model's expected outputs for each applied
// sample; a monitor pops one entry after each rising edge and compares.
// The reference model identifies codes by their position in the generated
// Johnson sequence rather than by decoding bits.

module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int NS = 2 * W;
  localparam int LK = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] code = '0;
  logic [2:0]   index;
  logic         valid, locked, err_illegal, err_seq;
  logic [7:0]   err_count;

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LK)) dut (
    .clk(clk), .rst(rst), .en(en), .code(code), .index(index),
    .valid(valid), .locked(locked), .err_illegal(err_illegal),
    .err_seq(err_seq), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic       v, l, ei, es;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [W-1:0] seq [NS];

  // reference model state
  int m_idx, m_prev, m_run, m_cnt;
  bit m_lock, m_first;

  function automatic int pos_of(input logic [W-1:0] c);
    for (int k = 0; k < NS; k++) if (seq[k] == c) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_prev = 0; m_run = 0; m_cnt = 0; m_lock = 0; m_first = 1;
  endtask

  task automatic sample(input logic e, input logic [W-1:0] c);
    exp_t x;
    int   p;
    @(negedge clk);
    en = e; code = c;
    x.v = 0; x.ei = 0; x.es = 0;
    if (e) begin
      p = pos_of(c);
      if (p < 0) begin
        x.ei = 1; m_run = 0; m_lock = 0;
        if (m_cnt < 255) m_cnt++;
      end else begin
        x.v = 1;
        if (m_first) m_first = 0;
        else if (p == (m_prev + 1) % NS) begin
          if (!m_lock) begin m_run++; if (m_run == LK) m_lock = 1; end
        end
`ifdef JOHNSON_DEC_STALL_EN
        else if (p == m_prev) begin end
`endif
        else begin
          if (m_lock) begin x.es = 1; if (m_cnt < 255) m_cnt++; end
          m_lock = 0; m_run = 0;
        end
        m_idx = p; m_prev = p;
      end
    end
    x.idx = 3'(m_idx); x.l = m_lock; x.cnt = 8'(m_cnt);
    q.push_back(x);
  endtask

  task automatic drain();
    @(negedge clk);
    en = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic feed(input int start, input int count);
    for (int k = 0; k < count; k++) sample(1'b1, seq[(start + k) % NS]);
  endtask

  // monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rst && q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (index !== x.idx || valid !== x.v || locked !== x.l ||
            err_illegal !== x.ei || err_seq !== x.es || err_count !== x.cnt) begin
          errors++;
          $display("FAIL sample: got idx=%0d v=%b l=%b ei=%b es=%b cnt=%0d, required idx=%0d v=%b l=%b ei=%b es=%b cnt=%0d",
                   index, valid, locked, err_illegal, err_seq, err_count,
                   x.idx, x.v, x.l, x.ei, x.es, x.cnt);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] c;
    seq[0] = '0;
    for (int k = 1; k < NS; k++) seq[k] = {seq[k-1][W-2:0], ~seq[k-1][W-1]};
    model_reset();

    // reset held for two cycles: everything low
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({index, valid, locked, err_illegal, err_seq, err_count} !== '0) begin
        errors++;
        $display("FAIL reset_state: got idx=%0d v=%b l=%b ei=%b es=%b cnt=%0d, required all 0",
                 index, valid, locked, err_illegal, err_seq, err_count);
      end
    end
    @(negedge clk); rst = 1;

    feed(0, 4);                      // reference + 3 steps: lock on 4th
    feed(4, 16);                     // two full laps incl. wrap 7->0
    sample(1'b1, 4'b0101);           // illegal while locked
    feed(2, 4);                      // 0011..1110: relock on 1110
    feed(6, 5);                      // 1100,1000,0000,0001,0011 (locked)
    sample(1'b1, 4'b1111);           // skip 2->4
    feed(5, 3);                      // relock at 1000
    feed(0, 4);                      // 0000..0111 locked
    sample(1'b1, 4'b0111);           // stall
    sample(1'b0, 4'b1010);           // en low: ignored
    drain();

    // randomized mix of in-order, random legal, random any, idle
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10)      sample(1'b0, 4'($urandom));
      else if (r < 70) sample(1'b1, seq[(m_prev + 1) % NS]);
      else if (r < 80) sample(1'b1, seq[m_prev]);
      else if (r < 90) sample(1'b1, seq[$urandom_range(0, NS - 1)]);
      else             sample(1'b1, 4'($urandom));
    end
    drain();

    // saturation
    for (int i = 0; i < 300; i++) begin
      do c = 4'($urandom); while (pos_of(c) >= 0);
      sample(1'b1, c);
    end
    drain();
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate: err_count=%0d, required 255", err_count);
    end

    // lock up again, then async reset between edges
    feed(0, 5);
    drain();
    @(posedge clk); #3;
    rst = 0;
    #1;
    checks++;
    if (err_count !== 8'd0 || locked !== 1'b0 || index !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d locked=%b idx=%0d, required 0 0 0",
               err_count, locked, index);
    end
    model_reset();
    @(negedge clk); rst = 1;

    // first legal sample after release is a reference point again
    feed(3, 5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the Johnson counter. Samples a WIDTH-bit Johnson code once per strobe and decodes it to a binary phase index. Checks that each code is legal and that successive samples advance by exactly one step, and tracks lock state. Sits wherever a Johnson-coded count crosses into logic that needs a binary phase or a health indication.

## Interface
- WIDTH, 4: Johnson code width; sequence length is N = 2*WIDTH (WIDTH >= 2).
- LOCK_CNT, 3: consecutive correct successor steps required to declare lock (1..15).
- IW, derived = $clog2(2*WIDTH): index width (3 for WIDTH=4).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sample strobe; code is consumed on a rising edge where en=1.
- code  in  WIDTH  Johnson code under test.
- index  out  IW  decoded phase of the last legal sample.
- valid  out  1  one-cycle pulse: a legal code was decoded on the previous sampling edge.
- locked  out  1  sequence lock status.
- err_illegal  out  1  one-cycle pulse: the sampled code is not a Johnson state.
- err_seq  out  1  one-cycle pulse: a legal code that is not the expected successor was sampled while locked.
- err_count  out  8  saturating total of err_illegal and err_seq events.

## Operation
- Sequence definition: the next code is {code[WIDTH-2:0], ~code[WIDTH-1]}, starting from all-zeros.
  - WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000, giving index 0..7.
- Legal code: has the form 0..01..1 or 1..10..0 (at most one 0/1 boundary). There are exactly N legal codes; every other code is illegal.
- Decode, with p = popcount(code):
  - code[WIDTH-1]=0: index = p.
  - code[WIDTH-1]=1: index = N - p.
- The block keeps prev_idx (last legal index) and a run counter run (0..LOCK_CNT).
- FSM states are HUNT and LOCKED. Each en sample is handled as follows:
  - Illegal code: err_illegal=1. index and prev_idx hold. run=0. Go to HUNT.
  - Legal code, idx == (prev_idx+1) mod N: valid=1. In HUNT, run increments; when run reaches LOCK_CNT, go to LOCKED.
  - Legal code, idx == prev_idx (stall): see Configuration.
  - Legal code, any other idx: valid=1. If LOCKED, err_seq=1 and go to HUNT. run=0.
  - Any legal code: index and prev_idx take idx.
- The first legal sample after reset is only a reference point: valid=1, run stays 0, no err_seq.
- Wrap-around: index N-1 followed by 0 is a correct successor step.
- err_count: increments by 1 on any edge where err_illegal or err_seq is asserted, and holds at 255. Only one error can occur per sample.
- en=0: all state holds, and all pulse outputs are 0.

## Timing
- Latency is 1 cycle. Outputs are registered and reflect the sample taken on the same rising edge.
- valid, err_illegal and err_seq are high for exactly one cycle per sampling edge. Back-to-back en gives back-to-back pulses.
- locked rises on the edge that completes the LOCK_CNT-th consecutive correct step. It falls on the edge of the offending sample.
- Reset values: index=0, valid=0, locked=0, err_illegal=0, err_seq=0, err_count=0, prev_idx=0, run=0, state HUNT, first-sample flag set.
- Reset asserted mid-operation clears everything immediately, without waiting for clk. The first legal sample after release is treated as the reference point again.

## Configuration
- JOHNSON_DEC_STALL_EN
  - Defined: a repeated idx is accepted. valid=1, no error, state and run unchanged. This tolerates a source counter that pauses.
  - Undefined: a repeated idx is treated as a wrong successor. It raises err_seq if LOCKED and resets run.

## Test plan
Parameters for all scenarios: WIDTH=4, LOCK_CNT=3.
- Reset and first samples: hold rst=0 for 2 cycles, then release and feed 0000,0001,0011,0111 with en=1 every cycle.
  - Required: all outputs are 0 during reset.
  - Required: index follows 0,1,2,3 with valid pulses.
  - Required: locked rises on the 4th sample.
- Full sequence and wrap: feed the 8-code sequence twice with en=1 every cycle.
  - Required: index runs 0..7,0..7; locked stays 1; err_count stays 0.
- Illegal code while locked: inject 0101.
  - Required: err_illegal pulses, locked drops, index holds at the previous value, err_count=1.
  - Then resume from 0011,0111,1111,1110. Required: relock on 1110.
- Sequence skip while locked: send 0011 then 1111 (index 2 then 4).
  - Required: err_seq pulses, locked=0, index=4.
- Stall: send 0111,0111 while locked.
  - Required with JOHNSON_DEC_STALL_EN defined: no error, locked stays 1.
  - Required with it undefined: err_seq pulses and locked drops.
- Saturation and async reset:
  - Force 300 illegal samples. Required: err_count=255.
  - Assert rst between clock edges. Required: err_count=0 and locked=0 before the next rising edge.
